postprocessing: RTL
===================

# postprocessing

Converts the CeNN array's signed fixed-point cell outputs back into displayable 8-bit pixels. It is the inverse of the input preprocessing path.
- Input: cell values in the 15-bit fixed-point format (1 sign, 5 integer, 9 fractional bits), in raster order.
- Processing: each value is saturated to [-1,1] and mapped linearly to a gray level (-1 → white, +1 → black), then replicated onto R/G/B for the demo display.
- Framing: line and frame markers are generated from a raster counter.
- Sits between the CeNN output buffer and the video/demo output, behind a two-stage valid/ready pipeline.

## Interface
Parameters:
- width_RGB, 8: output pixel width
- width_fixed, 15: input fixed-point width
- frac_bits, 9: fractional bits of input
- img_w, 64: pixels per line
- img_h, 64: lines per frame

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fixed carries a valid cell value
- in_ready  out  1  block accepts input this cycle
- fixed  in  width_fixed  signed two's-complement cell value
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- gray  out  width_RGB  gray level
- R, G, B  out  width_RGB  each equal to gray
- eol  out  1  beat is last pixel of a line
- eof  out  1  beat is last pixel of the frame
- sat_count  out  16  saturated samples in the last completed frame (only when POSTPROC_SAT_COUNT_EN is defined)

## Operation
- Input handshake: a beat is accepted when in_valid && in_ready. Output handshake: a beat is delivered when out_valid && out_ready.
- Stage 1 (saturate): with one = 1<<frac_bits (512):
  - raw > 512 → 512; raw < -512 → -512; otherwise unchanged.
  - A sat flag is set when clamping occurred.
- Stage 2 (map): gray = ((512 − xs)·255 + 512) >> 10.
  - Intermediate width: 19 bits unsigned, no overflow possible.
  - Result is always within 0..255.
  - Reference points: xs = −512 → 255; xs = 0 → 128; xs = 512 → 0.
- Stall rule: the pipeline advances as a whole when !out_valid || out_ready. in_ready equals that same term.
- While stalled, all outputs and stage registers hold stable.
- Raster counters col and row:
  - Increment only on output handshake.
  - col wraps to 0 after img_w−1, at which point row increments.
  - row wraps to 0 after img_h−1.
- Markers: eol = (col == img_w−1); eof = eol && (row == img_h−1). Both are valid only while out_valid.
- Reset values: out_valid 0, gray/R/G/B 0, eol 0, eof 0, col 0, row 0, sat_count 0, pipeline empty.
  - in_ready is 1 once reset is deasserted.
- Reset asserted mid-frame: in-flight beats are discarded and counters restart at pixel (0,0).

## Timing
- Latency: 2 cycles. A beat accepted at edge t appears with out_valid high after edge t+1; it is consumed at edge t+2 if out_ready.
- Throughput: 1 beat/cycle with out_ready held high.
- out_ready low with out_valid high: in_ready drops combinationally in the same cycle. No beat is lost or duplicated.
- Bubbles (in_valid low) propagate as out_valid low and do not advance the counters.
- Pipeline stages move together; there is no skid buffer.

## Configuration
- POSTPROC_SAT_COUNT_EN defined:
  - A 16-bit accumulator counts delivered beats whose sat flag is set, saturating at 0xFFFF.
  - On the eof handshake, the accumulator (including that beat) is copied to sat_count and the accumulator clears.
- Not defined: the sat_count port, the flag pipeline register and the accumulator are all absent. All other behaviour is identical.

## Structure
- Shared package cenn_pkg holds:
  - WIDTH_RGB, WIDTH_FIXED, FRAC_BITS constants.
  - typedef fixed_t (logic signed [WIDTH_FIXED-1:0]).
  - typedef pix_t (logic [WIDTH_RGB-1:0]).
  - Constant FIXED_ONE = 512.
- Sub-module fixed2uint: stages 1–2 (saturate + map) with stall enable. It is the inverse counterpart of uint2fixed.
- The top level holds the handshake, raster counters, markers and the optional saturation counter.

## Test plan
- Mapping: raw −512, 0, 256, 512 with out_ready = 1 → gray 255, 128, 64, 0 on consecutive cycles 2 cycles after input. R = G = B = gray.
- Saturation: raw 0x3FFF (16383) and 0x4000 (−16384) → gray 0 and 255. With POSTPROC_SAT_COUNT_EN, sat_count = 2 after eof.
- Backpressure: stream 10 beats and drop out_ready for 3 cycles mid-stream → in_ready low during the stall, outputs stable, all 10 beats delivered in order.
- Raster markers: img_w = 4, img_h = 2, 16 beats →
  - eol on beats 3, 7, 11, 15.
  - eof on beats 7 and 15.
  - Counters wrap to (0,0).
- Bubbles: in_valid toggling 1/0 → out_valid pattern delayed by 2 cycles; col advances only on valid beats.
- Reset mid-frame: assert rst_n low after 5 beats of a 4×2 frame → outputs cleared immediately. The next beat after release is col 0, and eol occurs on the 4th beat.

Source files
------------

// File: rtl/cenn_pkg.sv
// Shared CeNN fixed-point / pixel definitions used by the pre- and post-processing paths.
package cenn_pkg;

    localparam int WIDTH_RGB   = 8;
    localparam int WIDTH_FIXED = 15;
    localparam int FRAC_BITS   = 9;
    localparam int FIXED_ONE   = 32'd1 << FRAC_BITS;

    typedef logic signed [WIDTH_FIXED-1:0] fixed_t;
    typedef logic [WIDTH_RGB-1:0]          pix_t;

    // Saturating 16-bit increment, sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/fixed2uint.sv
// Two-stage saturate + linear map from signed fixed-point to an unsigned gray level.
// The sat flag output exists only when POSTPROC_SAT_COUNT_EN is defined.
module fixed2uint
    import cenn_pkg::*;
#(
    parameter int width_RGB   = WIDTH_RGB,
    parameter int width_fixed = WIDTH_FIXED,
    parameter int frac_bits   = FRAC_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          src_valid,
    input  logic signed [width_fixed-1:0] src,
    output logic                          dst_valid,
    output logic [width_RGB-1:0]          dst_gray
`ifdef POSTPROC_SAT_COUNT_EN
    ,
    output logic                          dst_sat
`endif
);

    localparam int XS_W  = frac_bits + 2;
    localparam int MAP_W = XS_W + width_RGB;
    localparam logic signed [width_fixed-1:0] POS_ONE = width_fixed'(32'sd1 << frac_bits);
    localparam logic signed [width_fixed-1:0] NEG_ONE = width_fixed'(-(32'sd1 << frac_bits));

    logic signed [XS_W-1:0]  xs_s;
    logic signed [XS_W-1:0]  xs_r;
    logic                    v1_r;
    logic [MAP_W-1:0]        diff_s;
    logic [MAP_W-1:0]        map_s;
    logic [width_RGB-1:0]    gray_s;
    logic                    map_unused_s;

    // Stage 1 combinational clamp to [-one, +one]; the clamped value fits XS_W bits.
    always_comb begin
        xs_s = XS_W'(src);
        if (src > POS_ONE) begin
            xs_s = XS_W'(POS_ONE);
        end else if (src < NEG_ONE) begin
            xs_s = XS_W'(NEG_ONE);
        end else begin
            xs_s = XS_W'(src);
        end
    end

    // Stage 2 combinational map: ((one - xs) * 255 + one) >> (frac_bits + 1).
    always_comb begin
        diff_s = MAP_W'(32'd1 << frac_bits) - {{width_RGB{xs_r[XS_W-1]}}, xs_r};
        map_s  = diff_s * MAP_W'((32'd1 << width_RGB) - 32'd1) + MAP_W'(32'd1 << frac_bits);
        gray_s = map_s[frac_bits+1 +: width_RGB];
    end

    assign map_unused_s = ^{map_s[MAP_W-1], map_s[frac_bits:0]};

    // Both stages advance together under the shared enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            xs_r      <= '0;
            dst_valid <= 1'b0;
            dst_gray  <= '0;
        end else if (en) begin
            v1_r      <= src_valid;
            xs_r      <= xs_s;
            dst_valid <= v1_r;
            dst_gray  <= gray_s;
        end
    end

`ifdef POSTPROC_SAT_COUNT_EN
    logic sat_s;
    logic sat1_r;

    assign sat_s = (src > POS_ONE) || (src < NEG_ONE);

    // Clamp flag travels alongside the data through both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat1_r  <= 1'b0;
            dst_sat <= 1'b0;
        end else if (en) begin
            sat1_r  <= sat_s;
            dst_sat <= sat1_r;
        end
    end
`endif

endmodule

// File: rtl/postprocessing.sv
// CeNN output post-processing: fixed-point cell values -> gray/RGB pixels with raster markers.
// Define POSTPROC_SAT_COUNT_EN to add the per-frame saturation counter (sat_count port).
module postprocessing
    import cenn_pkg::*;
#(
    parameter int width_RGB   = WIDTH_RGB,
    parameter int width_fixed = WIDTH_FIXED,
    parameter int frac_bits   = FRAC_BITS,
    parameter int img_w       = 64,
    parameter int img_h       = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [width_fixed-1:0] fixed,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [width_RGB-1:0]          gray,
    output logic [width_RGB-1:0]          R,
    output logic [width_RGB-1:0]          G,
    output logic [width_RGB-1:0]          B,
    output logic                          eol,
    output logic                          eof
`ifdef POSTPROC_SAT_COUNT_EN
    ,
    output logic [15:0]                   sat_count
`endif
);

    localparam int CW = (img_w > 1) ? $clog2(img_w) : 1;
    localparam int RW = (img_h > 1) ? $clog2(img_h) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(img_w - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(img_h - 1);

    logic          adv_s;
    logic          fire_s;
    logic          col_last_s;
    logic          row_last_s;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;

    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;
    assign fire_s   = out_valid && out_ready;

`ifdef POSTPROC_SAT_COUNT_EN
    logic sat_s;
`endif

    fixed2uint #(
        .width_RGB  (width_RGB),
        .width_fixed(width_fixed),
        .frac_bits  (frac_bits)
    ) u_map (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (adv_s),
        .src_valid(in_valid),
        .src      (fixed),
        .dst_valid(out_valid),
        .dst_gray (gray)
`ifdef POSTPROC_SAT_COUNT_EN
        ,
        .dst_sat  (sat_s)
`endif
    );

    assign R = gray;
    assign G = gray;
    assign B = gray;

    // col/row always name the raster position of the beat currently on the output.
    assign col_last_s = (col_r == COL_LAST);
    assign row_last_s = (row_r == ROW_LAST);
    assign eol        = out_valid && col_last_s;
    assign eof        = eol && row_last_s;

    // Raster counters step only on a delivered beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= '0;
            row_r <= '0;
        end else if (fire_s) begin
            if (col_last_s) begin
                col_r <= '0;
                row_r <= row_last_s ? '0 : row_r + RW'(1);
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

`ifdef POSTPROC_SAT_COUNT_EN
    logic [15:0] acc_r;
    logic [15:0] acc_next_s;

    // Accumulator value including the beat being delivered this cycle.
    always_comb begin
        acc_next_s = acc_r;
        if (fire_s && sat_s) begin
            acc_next_s = sat_inc16(acc_r);
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Publish the frame total on the eof handshake and restart counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= 16'd0;
            sat_count <= 16'd0;
        end else if (fire_s && eof) begin
            sat_count <= acc_next_s;
            acc_r     <= 16'd0;
        end else begin
            acc_r     <= acc_next_s;
        end
    end
`endif

endmodule
